// File: rtl/pack_recv.sv
// pack_recv: receive-side de-framer for the trace link.
// Hunts FF FF FF 7F sync, buffers 16-byte frames, serves them word by word.
module pack_recv #(
  parameter int NPKT         = 4,
  parameter int IDLE_TIMEOUT = 4096,
  parameter int OVF_STRETCH  = 2047
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ByteAvail,
  input  logic [7:0]  ByteVal,
  output logic        ByteNext,
  output logic        PacketAvail,
  input  logic        PacketNext,
  input  logic        PacketNextWd,
  output logic [15:0] PacketOut,
  output logic        InSync,
  output logic        FrameOverf
);
  localparam int SW = $clog2(NPKT);
  localparam int CW = $clog2(NPKT + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam int OW = $clog2(OVF_STRETCH + 1);
  localparam logic [CW-1:0] FULL  = CW'(NPKT);
  localparam logic [TW-1:0] TLAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [OW-1:0] OLOAD = OW'(OVF_STRETCH);

  typedef enum logic {HUNT, FRAME} state_t;
  state_t state, state_nx;

  logic [1:0]    cool;
  logic [1:0]    sync_cnt;
  logic [3:0]    idx;
  logic [1:0]    ff_run;
  logic [7:0]    lo;
  logic          discard;
  logic [TW-1:0] idle;
  logic [OW-1:0] ovf;
  logic [SW-1:0] wr_slot;
  logic [SW-1:0] rd_slot;
  logic [SW-1:0] open_slot;
  logic [SW-1:0] open_slot_nx;
  logic [CW-1:0] complete;
  logic [CW-1:0] occ;
  logic          open;
  logic          open_nx;
  logic [2:0]    wd;
  logic [2:0]    wd_nx;
  logic [15:0]   mem [NPKT*8];

  logic cap, is_ff, is_7f;
  logic sync_hit, restart, timeout;
  logic last, commit, drop, take, wr_en;

  assign cap      = ByteAvail && cool == 2'd0;
  assign is_ff    = ByteVal == 8'hFF;
  assign is_7f    = ByteVal == 8'h7F;
  assign sync_hit = cap && state == HUNT && is_7f && sync_cnt == 2'd3;
  assign restart  = cap && state == FRAME && idx == 4'd3
                    && ff_run == 2'd3 && is_7f;
  assign timeout  = state == FRAME && idx != 4'd0 && !cap
                    && idle == TLAST;
  assign last     = cap && state == FRAME && idx == 4'd15;
  assign commit   = last && !discard;
  assign drop     = last && discard;
  assign take     = PacketNext && complete != '0;
  assign occ      = complete + CW'(open);
  assign wr_en    = cap && state == FRAME && idx[0]
                    && !discard && !restart;

  assign PacketAvail = complete != '0;
  assign FrameOverf  = ovf != '0;

  always_ff @(posedge clk)
    if (!rst) state <= HUNT;
    else      state <= state_nx;

  always_comb begin
    state_nx = state;
    unique case (state)
      HUNT:  if (sync_hit) state_nx = FRAME;
      FRAME: if (timeout)  state_nx = HUNT;
    endcase
  end

  always_comb begin
    InSync = 1'b0;
    unique case (state)
      HUNT:  InSync = 1'b0;
      FRAME: InSync = 1'b1;
    endcase
  end

  // Two dead edges after each capture pace the source handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cool     <= '0;
      ByteNext <= 1'b0;
    end else begin
      ByteNext <= cap;
      if (cap)               cool <= 2'd2;
      else if (cool != 2'd0) cool <= cool - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_cnt <= '0;
      idx      <= '0;
      ff_run   <= '0;
      lo       <= '0;
      discard  <= 1'b0;
      idle     <= '0;
    end else if (state == HUNT) begin
      idx     <= '0;
      ff_run  <= '0;
      discard <= 1'b0;
      idle    <= '0;
      if (cap) begin
        if (!is_ff)                 sync_cnt <= '0;
        else if (sync_cnt != 2'd3) sync_cnt <= sync_cnt + 2'd1;
      end
    end else if (timeout) begin
      idx      <= '0;
      ff_run   <= '0;
      discard  <= 1'b0;
      idle     <= '0;
      sync_cnt <= '0;
    end else if (cap) begin
      idle <= '0;
      if (restart) begin
        idx     <= '0;
        ff_run  <= '0;
        discard <= 1'b0;
      end else begin
        idx <= idx + 4'd1;
        if (idx == 4'd0) begin
          discard <= occ == FULL;
          ff_run  <= {1'b0, is_ff};
        end else if (idx < 4'd3 && is_ff && ff_run == idx[1:0]) begin
          ff_run <= ff_run + 2'd1;
        end
        if (!idx[0]) lo <= ByteVal;
      end
    end else if (idx != 4'd0) begin
      idle <= idle + TW'(1);
    end else begin
      idle <= '0;
    end
  end

  always_ff @(posedge clk)
    if (wr_en) mem[{wr_slot, idx[3:1]}] <= {ByteVal, lo};

  always_comb begin
    open_nx      = open;
    open_slot_nx = open_slot;
    wd_nx        = wd;
    if (PacketNext) begin
      open_nx = take;
      wd_nx   = '0;
      if (take) open_slot_nx = rd_slot;
    end else if (PacketNextWd && open && wd != 3'd7) begin
      wd_nx = wd + 3'd1;
    end
  end

  // Read address uses next-state pointers so the word lands one cycle after a strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_slot   <= '0;
      rd_slot   <= '0;
      open_slot <= '0;
      complete  <= '0;
      open      <= 1'b0;
      wd        <= '0;
      PacketOut <= '0;
      ovf       <= '0;
    end else begin
      open      <= open_nx;
      open_slot <= open_slot_nx;
      wd        <= wd_nx;
      if (take)   rd_slot <= rd_slot + SW'(1);
      if (commit) wr_slot <= wr_slot + SW'(1);
      complete <= complete + CW'(commit) - CW'(take);
      if (open_nx) PacketOut <= mem[{open_slot_nx, wd_nx}];
      if (drop)              ovf <= OLOAD;
      else if (ovf != '0)    ovf <= ovf - OW'(1);
    end
  end
endmodule
